// File: rtl/rex_pkg.sv
// ============================================================
// Package : rex_pkg
// Shared state encoding and widths for the Rex runner controller.
// Rev     : 1.0
// ============================================================
`default_nettype none

package rex_pkg;

    localparam int SPEED_W = 4;

    typedef enum logic [5:0] {
        ST_START = 6'b000001,
        ST_RUN   = 6'b000010,
        ST_JUMP  = 6'b000100,
        ST_DUCK  = 6'b001000,
        ST_PAUSE = 6'b010000,
        ST_STOP  = 6'b100000
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rex_tick_gen.sv
// ============================================================
// Module : rex_tick_gen
// TICK_DIV prescaler with hold/clear and a registered tick pulse.
// Rev    : 1.0
// ============================================================
`default_nettype none

module rex_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    // While held, the pending tick is frozen too, so it is consumed after resume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (clear) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (!hold) begin
            if (r_cnt == CNT_W'(TICK_DIV - 1)) begin
                r_cnt  <= '0;
                r_tick <= 1'b0;
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
                r_tick <= (r_cnt == CNT_W'(TICK_DIV - 2));
            end
        end
    end

    assign tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/rex_runner_ctrl.sv
// ============================================================
// Module : rex_runner_ctrl
// Runner FSM with signed jump physics, score/speed and high score.
// Rev    : 1.0
// ============================================================
`default_nettype none

module rex_runner_ctrl
    import rex_pkg::*;
#(
    parameter int TICK_DIV   = 4,
    parameter int POS_W      = 8,
    parameter int JUMP_V0    = 12,
    parameter int GRAVITY    = 1,
    parameter int SCORE_W    = 16,
    parameter int SPEED_INIT = 1,
    parameter int SPEED_MAX  = 15,
    parameter int SPEED_STEP = 100
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Restart,
    input  logic               Jump,
    input  logic               Duck,
    input  logic               Pause,
    input  logic               Hit,
    output logic               q_Start,
    output logic               q_Run,
    output logic               q_Jump,
    output logic               q_Duck,
    output logic               q_Pause,
    output logic               q_Stop,
    output logic               tick,
    output logic [POS_W-1:0]   y_pos,
    output logic [SPEED_W-1:0] speed,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_high
);

    localparam int VW     = POS_W + 1;
    localparam int SW     = POS_W + 2;
    localparam int STEP_W = $clog2(SPEED_STEP + 1);
    localparam logic signed [SW-1:0] Y_MAX = SW'((2 ** POS_W) - 1);

    state_t r_state, r_resume, w_state_next, w_after;

    logic                     r_jump_d;
    logic [POS_W-1:0]         r_y;
    logic signed [VW-1:0]     r_vy;
    logic [SCORE_W-1:0]       r_score, r_high, w_score_nxt;
    logic [SPEED_W-1:0]       r_speed;
    logic [STEP_W-1:0]        r_step;
    logic                     r_new_high;

    logic                     w_jump_edge, w_active, w_phys, w_land, w_ceil;
    logic                     w_launch, w_restart, w_enter_stop, w_score_tick;
    logic signed [SW-1:0]     w_y_sum;
    logic signed [VW-1:0]     w_g;

    rex_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (Clk),
        .rst   (Reset),
        .hold  (r_state == ST_PAUSE),
        .clear ((r_state == ST_START) || (r_state == ST_STOP)),
        .tick  (tick)
    );

    assign w_jump_edge  = Jump && !r_jump_d;
    assign w_active     = (r_state == ST_RUN) || (r_state == ST_JUMP) || (r_state == ST_DUCK);
    assign w_phys       = (r_state == ST_JUMP) && tick;
    assign w_score_tick = w_active && tick;
    assign w_restart    = (r_state == ST_STOP) && Restart;
    assign w_enter_stop = w_active && Hit;
    assign w_launch     = ((r_state == ST_RUN) || (r_state == ST_DUCK)) && (w_state_next == ST_JUMP);

    assign w_y_sum = $signed({2'b00, r_y}) + $signed({r_vy[VW-1], r_vy});
    assign w_g     = Duck ? VW'(2 * GRAVITY) : VW'(GRAVITY);
    assign w_land  = w_phys && r_vy[VW-1] && (w_y_sum[SW-1] || (w_y_sum == '0));
    assign w_ceil  = !w_y_sum[SW-1] && (w_y_sum > Y_MAX);

    assign w_score_nxt = (w_score_tick && !(&r_score)) ? r_score + SCORE_W'(1) : r_score;

    always_comb begin
        w_after = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_jump_edge)  w_after = ST_JUMP;
                else if (Duck)    w_after = ST_DUCK;
            end
            ST_DUCK: begin
                if (w_jump_edge)  w_after = ST_JUMP;
                else if (!Duck)   w_after = ST_RUN;
            end
            ST_JUMP: begin
                if (w_land)       w_after = Duck ? ST_DUCK : ST_RUN;
            end
            default: ;
        endcase

        w_state_next = r_state;
        case (r_state)
            ST_START: if (Start) w_state_next = ST_RUN;
            ST_RUN, ST_JUMP, ST_DUCK: begin
                if (Hit)        w_state_next = ST_STOP;
                else if (Pause) w_state_next = ST_PAUSE;
                else            w_state_next = w_after;
            end
            ST_PAUSE: if (!Pause)  w_state_next = r_resume;
            ST_STOP:  if (Restart) w_state_next = ST_START;
            default:               w_state_next = ST_START;
        endcase
    end

    // A pause on the landing tick resumes into the post-landing state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= ST_START;
            r_resume <= ST_RUN;
            r_jump_d <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_jump_d <= Jump;
            if (w_active && !Hit && Pause)
                r_resume <= (r_state == ST_JUMP) ? w_after : r_state;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_y  <= '0;
            r_vy <= '0;
        end else if (w_restart) begin
            r_y  <= '0;
            r_vy <= '0;
        end else if (w_phys) begin
            if (w_land) begin
                r_y  <= '0;
                r_vy <= '0;
            end else begin
                r_y  <= w_ceil ? '1 : w_y_sum[POS_W-1:0];
                r_vy <= r_vy - w_g;
            end
        end else if (w_launch) begin
            r_vy <= VW'(JUMP_V0);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_score    <= '0;
            r_high     <= '0;
            r_speed    <= SPEED_W'(SPEED_INIT);
            r_step     <= '0;
            r_new_high <= 1'b0;
        end else if (w_restart) begin
            r_score    <= '0;
            r_speed    <= SPEED_W'(SPEED_INIT);
            r_step     <= '0;
            r_new_high <= 1'b0;
        end else begin
            r_score <= w_score_nxt;
            if (w_score_tick) begin
                if (r_step == STEP_W'(SPEED_STEP - 1)) begin
                    r_step <= '0;
                    if (r_speed != SPEED_W'(SPEED_MAX))
                        r_speed <= r_speed + SPEED_W'(1);
                end else begin
                    r_step <= r_step + STEP_W'(1);
                end
            end
            // Compare against the score STOP will hold, including a same-edge tick.
            if (w_enter_stop && (w_score_nxt > r_high)) begin
                r_high     <= w_score_nxt;
                r_new_high <= 1'b1;
            end
        end
    end

    assign q_Start    = (r_state == ST_START);
    assign q_Run      = (r_state == ST_RUN);
    assign q_Jump     = (r_state == ST_JUMP);
    assign q_Duck     = (r_state == ST_DUCK);
    assign q_Pause    = (r_state == ST_PAUSE);
    assign q_Stop     = (r_state == ST_STOP);
    assign y_pos      = r_y;
    assign speed      = r_speed;
    assign score      = r_score;
    assign high_score = r_high;
    assign new_high   = r_new_high;

endmodule

`default_nettype wire

// File: tb/tb_rex_runner_ctrl.sv
// ============================================================
// Module : tb_rex_runner_ctrl
// Directed scenarios plus random play against a behavioural game model.
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_rex_runner_ctrl;

    localparam int TICK_DIV = 4, SPEED_INIT = 1, SPEED_MAX = 15, SPEED_STEP = 100;
    localparam int JUMP_V0 = 12, GRAVITY = 1, Y_MAX = 255, SCORE_MAX = 65535;
    localparam int M_START = 0, M_RUN = 1, M_JUMP = 2, M_DUCK = 3, M_PAUSE = 4, M_STOP = 5;

    logic Clk = 1'b0;
    logic Reset, Start, Restart, Jump, Duck, Pause, Hit;
    logic q_Start, q_Run, q_Jump, q_Duck, q_Pause, q_Stop, tick, new_high;
    logic [7:0]  y_pos;
    logic [3:0]  speed;
    logic [15:0] score, high_score;

    rex_runner_ctrl dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Restart(Restart), .Jump(Jump),
        .Duck(Duck), .Pause(Pause), .Hit(Hit),
        .q_Start(q_Start), .q_Run(q_Run), .q_Jump(q_Jump), .q_Duck(q_Duck),
        .q_Pause(q_Pause), .q_Stop(q_Stop), .tick(tick), .y_pos(y_pos),
        .speed(speed), .score(score), .high_score(high_score), .new_high(new_high)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Game model: whole-number physics and rules, one call per clock edge.
    int m_st, m_res, m_y, m_vy, m_score, m_high, m_new, m_speed, m_steps, m_cnt, m_tick, m_jprev;

    function automatic void model_reset();
        m_st = M_START; m_res = M_RUN; m_y = 0; m_vy = 0; m_score = 0; m_high = 0;
        m_new = 0; m_speed = SPEED_INIT; m_steps = 0; m_cnt = 0; m_tick = 0; m_jprev = 0;
    endfunction

    function automatic void model_step();
        int  nst, after, ny;
        bit  jedge, active, land;
        jedge  = Jump && !m_jprev;
        active = (m_st == M_RUN) || (m_st == M_JUMP) || (m_st == M_DUCK);
        land   = 0;
        if (m_st == M_JUMP && m_tick != 0) begin
            ny = m_y + m_vy;
            if (m_vy < 0 && ny <= 0) begin
                land = 1; m_y = 0; m_vy = 0;
            end else begin
                m_y  = (ny > Y_MAX) ? Y_MAX : ny;
                m_vy = m_vy - (Duck ? 2 * GRAVITY : GRAVITY);
            end
        end
        if (active && m_tick != 0) begin
            if (m_score < SCORE_MAX) m_score++;
            m_steps++;
            if (m_steps == SPEED_STEP) begin
                m_steps = 0;
                if (m_speed < SPEED_MAX) m_speed++;
            end
        end
        nst = m_st;
        case (m_st)
            M_START: if (Start) nst = M_RUN;
            M_RUN, M_DUCK, M_JUMP: begin
                after = m_st;
                if (m_st == M_JUMP) begin
                    if (land) after = Duck ? M_DUCK : M_RUN;
                end else if (jedge) after = M_JUMP;
                else if (m_st == M_RUN && Duck) after = M_DUCK;
                else if (m_st == M_DUCK && !Duck) after = M_RUN;
                if (Hit) begin
                    nst = M_STOP;
                    if (m_score > m_high) begin m_high = m_score; m_new = 1; end
                end else if (Pause) begin
                    nst = M_PAUSE;
                    m_res = (m_st == M_JUMP) ? after : m_st;
                end else begin
                    nst = after;
                    if (after == M_JUMP && m_st != M_JUMP) m_vy = JUMP_V0;
                end
            end
            M_PAUSE: if (!Pause) nst = m_res;
            default: if (Restart) begin
                nst = M_START; m_score = 0; m_y = 0; m_vy = 0;
                m_speed = SPEED_INIT; m_steps = 0; m_new = 0;
            end
        endcase
        if (m_st == M_START || m_st == M_STOP) begin
            m_cnt = 0; m_tick = 0;
        end else if (m_st != M_PAUSE) begin
            m_cnt  = (m_cnt + 1) % TICK_DIV;
            m_tick = (m_cnt == TICK_DIV - 1) ? 1 : 0;
        end
        m_jprev = Jump;
        m_st    = nst;
    endfunction

    task automatic check_all();
        check("state", 32'({q_Stop, q_Pause, q_Duck, q_Jump, q_Run, q_Start}), 32'(1 << m_st));
        check("tick", 32'(tick), m_tick);
        check("y_pos", 32'(y_pos), m_y);
        check("score", 32'(score), m_score);
        check("speed", 32'(speed), m_speed);
        check("high_score", 32'(high_score), m_high);
        check("new_high", 32'(new_high), m_new);
    endtask

    task automatic cycle();
        @(posedge Clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        int ymax, nticks;
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ymax, nticks;
        {Start, Restart, Jump, Duck, Pause, Hit} = '0;
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        model_reset();
        check_all();

        // Reset then start
        Start = 1; cycle(); Start = 0;
        check("run_entry", 32'(q_Run), 1);
        repeat (4) cycle();
        check("first_score", 32'(score), 1);

        // Full jump
        Jump = 1; cycle(); Jump = 0;
        ymax = 0;
        for (int i = 0; i < 200 && !(q_Run && y_pos == 0 && ymax > 0); i++) begin
            cycle();
            if (int'(y_pos) > ymax) ymax = int'(y_pos);
        end
        check("jump_peak", 32'(ymax), 78);
        check("jump_landed_run", 32'(q_Run && y_pos == 0), 1);

        // Pause mid-jump
        Jump = 1; cycle(); Jump = 0;
        for (int i = 0; i < 100 && y_pos != 8'd50; i++) cycle();
        check("pause_reach_50", 32'(y_pos), 50);
        Pause = 1;
        repeat (40) cycle();
        check("pause_y_frozen", 32'(y_pos), 50);
        check("pause_state", 32'(q_Pause), 1);
        Pause = 0;
        for (int i = 0; i < 20 && y_pos == 8'd50; i++) cycle();
        check("resume_y", 32'(y_pos), 57);
        for (int i = 0; i < 200 && q_Jump; i++) cycle();

        // Fast-fall from the peak
        Jump = 1; cycle(); Jump = 0;
        for (int i = 0; i < 100 && y_pos != 8'd78; i++) cycle();
        Duck = 1;
        nticks = 12;
        for (int i = 0; i < 200 && q_Jump; i++) begin
            if (tick) nticks++;
            cycle();
        end
        check("ff_early_land", 32'(nticks < 25), 1);
        check("ff_y_zero", 32'(y_pos), 0);
        check("ff_duck", 32'(q_Duck), 1);
        Duck = 0; cycle();

        // Collision and high score
        for (int i = 0; i < 4000 && score != 16'd230; i++) cycle();
        Hit = 1; cycle(); Hit = 0;
        check("hit_stop", 32'(q_Stop), 1);
        check("hit_high", 32'(high_score), 230);
        check("hit_new_high", 32'(new_high), 1);
        check("hit_speed", 32'(speed), 3);
        Restart = 1; cycle(); Restart = 0;
        check("restart_score", 32'(score), 0);
        check("restart_speed", 32'(speed), 1);
        check("restart_high", 32'(high_score), 230);
        Start = 1; cycle(); Start = 0;
        for (int i = 0; i < 1000 && score != 16'd100; i++) cycle();
        Hit = 1; cycle(); Hit = 0;
        check("run2_high", 32'(high_score), 230);
        check("run2_new_high", 32'(new_high), 0);

        // Restart with Start in STOP, then simultaneous Hit/Pause/Jump edge
        Restart = 1; Start = 1; cycle(); Restart = 0;
        check("restart_start_first", 32'(q_Start), 1);
        cycle(); Start = 0;
        check("restart_start_next", 32'(q_Run), 1);
        repeat (6) cycle();
        Hit = 1; Pause = 1; Jump = 1; cycle();
        {Hit, Pause, Jump} = '0;
        check("simul_stop", 32'(q_Stop), 1);

        // Asynchronous reset mid-jump
        Restart = 1; cycle(); Restart = 0;
        Start = 1; cycle(); Start = 0;
        Jump = 1; cycle(); Jump = 0;
        repeat (14) cycle();
        #2 Reset = 1'b1;
        #1;
        check("areset_y", 32'(y_pos), 0);
        check("areset_start", 32'(q_Start), 1);
        check("areset_high", 32'(high_score), 0);
        @(posedge Clk);
        #1 Reset = 1'b0;
        model_reset();
        check_all();

        // Random play
        for (int i = 0; i < 6000; i++) begin
            Start   = ($urandom_range(0, 9) < 3);
            Restart = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0)  Jump = ~Jump;
            if ($urandom_range(0, 19) == 0) Duck = ~Duck;
            if (Pause) Pause = ($urandom_range(0, 14) != 0);
            else       Pause = ($urandom_range(0, 149) == 0);
            Hit = ($urandom_range(0, 299) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
